// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer. It issues sequential word fetches to a
// variable-latency imem, keeps the returned {pc, inst} pairs in an in-order
// FIFO, and feeds the IF stage. A redirect flushes the FIFO and drops any
// responses still in flight.
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned PTR_WIDTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned FW = PTR_WIDTH + 1;
  localparam int unsigned AW = ((FW > CNT_WIDTH) ? FW : CNT_WIDTH) + 1;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t                 state_q;
  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            resp_pc_q, resp_pc_d;
  logic [FW-1:0]          count_q, count_d;
  logic [CNT_WIDTH-1:0]   outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]            last_pc_q, last_inst_q;
  logic [31:0]            pc_mem   [DEPTH];
  logic [31:0]            inst_mem [DEPTH];

  logic [AW-1:0]          in_use;
  logic                   accept, push, pop;

  // Credit check, request handshake and all next-state values.
  always_comb begin
    // Slots already committed: live in-flight requests plus buffered entries.
    in_use         = AW'(outstanding_q) - AW'(drop_q) + AW'(count_q);
    imem_req_valid = ~reset & ~redirect
                   & (outstanding_q < CNT_WIDTH'(MAX_OUTSTANDING))
                   & (in_use < AW'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    if_valid       = (count_q != '0);
    if_pc          = if_valid ? pc_mem[rd_ptr_q]   : last_pc_q;
    if_inst        = if_valid ? inst_mem[rd_ptr_q] : last_inst_q;

    accept = imem_req_valid & imem_req_ready;
    push   = imem_resp_valid & ~redirect & (drop_q == '0);
    pop    = if_valid & if_ready & ~redirect;

    outstanding_d = outstanding_q + CNT_WIDTH'(accept) - CNT_WIDTH'(imem_resp_valid);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect) begin
      // A response landing in the redirect cycle is itself stale and retires
      // one of the outstanding requests, so it is not counted for dropping.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = rd_ptr_q;
      drop_d     = outstanding_q - CNT_WIDTH'(imem_resp_valid);
    end else begin
      if (accept)                            fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_resp_valid && drop_q != '0)   drop_d     = drop_q - 1'b1;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop)                               rd_ptr_d   = rd_ptr_q + 1'b1;
      count_d = count_q + FW'(push) - FW'(pop);
    end
  end

  // Control registers and the FETCH/DRAIN state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= '0;
      resp_pc_q     <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      last_pc_q     <= '0;
      last_inst_q   <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      last_pc_q     <= if_pc;
      last_inst_q   <= if_inst;
      if (redirect)
        state_q <= (drop_d != '0) ? DRAIN : FETCH;
      else if (state_q == DRAIN && drop_d == '0)
        state_q <= FETCH;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      inst_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

  a_outstanding_max: assert property (@(posedge clk) disable iff (reset)
    outstanding_q <= CNT_WIDTH'(MAX_OUTSTANDING));
  a_count_max: assert property (@(posedge clk) disable iff (reset)
    count_q <= FW'(DEPTH));

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: an imem responder with
// configurable latency, and a scoreboard of {pc, inst} pairs pushed on each
// accepted request and popped when the IF stage consumes an entry.
module tb_inst_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_prefetch_buffer #(
    .DEPTH(4), .PTR_WIDTH(2), .MAX_OUTSTANDING(2), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] sb_q[$];
  logic [31:0] log_q[$];
  int          total = 0;
  int          bad = 0;
  int          inflight = 0;
  int          pop_count = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  logic [31:0] exp_fetch = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input int idx, input logic [31:0] exp);
    if (log_q.size() > idx) check("popped_pc", log_q[idx], exp);
    else                    check("popped_len", 32'(log_q.size()), 32'(idx + 1));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // imem model: answers strictly in order once each request's latency elapses.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = inst_of(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // Monitor: samples mid-cycle, records accepts and checks every IF pop.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        exp_fetch = '0;
        inflight  = 0;
      end else begin
        if (imem_resp_valid) inflight--;
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_fetch);
          sb_q.push_back({imem_req_addr, inst_of(imem_req_addr)});
          pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
          exp_fetch += 32'd4;
          inflight++;
          check("inflight_le_max", 32'(inflight <= 2), 32'd1);
        end
        if (if_valid && if_ready && !redirect) begin
          check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("if_pc", if_pc, e[63:32]);
            check("if_inst", if_inst, e[31:0]);
            log_q.push_back(if_pc);
            pop_count++;
          end
        end
        if (redirect) begin
          check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
          sb_q.delete();
          exp_fetch = redirect_pc;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) step();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);

    // Streaming with 1-cycle latency: one entry per cycle after fill.
    lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
    log_q.delete(); pop_count = 0;
    reset = 1'b0;
    repeat (25) step();
    check("throughput", 32'(pop_count >= 20), 32'd1);
    check_log(0, 32'h0); check_log(1, 32'h4); check_log(2, 32'h8);

    // Stall: FIFO fills to DEPTH, requests stop, nothing lost.
    reset = 1'b1; if_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    check("stall_buffered", 32'(sb_q.size()), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_if_valid", 32'(if_valid), 32'd1);
    check("stall_head_pc", if_pc, 32'h0);
    check("stall_head_inst", if_inst, inst_of(32'h0));
    log_q.delete(); if_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 5; i++) check_log(i, 32'(4 * i));

    // Redirect with two requests outstanding at latency 3.
    lat = 3;
    repeat (8) step();
    n = 0;
    while (!(pend_q.size() == 2 && !imem_resp_valid) && n < 30) begin step(); n++; end
    check("wait_two_outstanding", 32'(n < 30), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("redir_fifo_empty", 32'(if_valid), 32'd0);
    check("redir_out_full", 32'(imem_req_valid), 32'd0);
    log_q.delete();
    repeat (20) step();
    check_log(0, 32'h100); check_log(1, 32'h104);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    repeat (6) step();
    n = 0;
    while (!(imem_resp_valid && if_valid) && n < 30) begin step(); n++; end
    check("wait_resp_and_pop", 32'(n < 30), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("redir2_fifo_empty", 32'(if_valid), 32'd0);
    log_q.delete();
    repeat (15) step();
    check_log(0, 32'h200); check_log(1, 32'h204);

    // Random ready toggling and latencies of 1-4 cycles.
    repeat (400) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      if_ready       = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 4);
      step();
    end
    imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1;
    log_q.delete();
    repeat (15) step();
    check("post_random_flow", 32'(log_q.size() >= 10), 32'd1);

    // Reset with two requests in flight; late responses arrive during reset.
    lat = 4;
    n = 0;
    while (inflight != 2 && n < 30) begin step(); n++; end
    check("wait_inflight_two", 32'(n < 30), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_if_valid", 32'(if_valid), 32'd0);
    repeat (8) step();
    check("late_resp_drained", 32'(pend_q.size()), 32'd0);
    log_q.delete();
    reset = 1'b0;
    check("post_rst_if_valid", 32'(if_valid), 32'd0);
    n = 0;
    while (!imem_resp_valid && n < 10) begin
      step();
      check("wait_first_resp_if_valid", 32'(if_valid), 32'd0);
      n++;
    end
    repeat (20) step();
    check_log(0, 32'h0); check_log(1, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
